// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose:
//   Shares one single-port instruction BRAM (1-cycle registered read) between
//   the instruction-fetch port (IF_*) and the debug port (DBG_*). At most one
//   read is outstanding. A response is passed straight through from the BRAM
//   in the cycle after the grant. If the owner is not ready to take it, the
//   word is parked in a hold register until the owner accepts it.
//
// Configuration macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin on contention (port not granted
//                                last wins; pointer moves on every grant)
//                   undefined -> fixed priority, IF over DBG
//
// Ports:
//   CLK, RST_N                       clock, async active-low reset
//   IF_REQ_VALID/IF_REQ_READY        fetch request handshake
//   IF_ADDR                          fetch byte address
//   IF_RSP_VALID/IF_RSP_READY        fetch response handshake
//   IF_RDATA                         fetch response data
//   DBG_*                            same set for the debug port
//   MEM_EN, MEM_ADDR, MEM_RDATA      BRAM read port
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  IF_REQ_VALID,
    output logic                  IF_REQ_READY,
    input  logic [ADDR_WIDTH-1:0] IF_ADDR,
    output logic                  IF_RSP_VALID,
    input  logic                  IF_RSP_READY,
    output logic [31:0]           IF_RDATA,

    input  logic                  DBG_REQ_VALID,
    output logic                  DBG_REQ_READY,
    input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
    output logic                  DBG_RSP_VALID,
    input  logic                  DBG_RSP_READY,
    output logic [31:0]           DBG_RDATA,

    output logic                  MEM_EN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic [31:0]           MEM_RDATA
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    localparam logic OwnIf  = 1'b0;
    localparam logic OwnDbg = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] hold_q,  hold_d;
`ifdef IMEM_ARB_RR_EN
    logic        lastDbg_q, lastDbg_d;
`endif

    logic        rspActive;
    logic        ownerRspReady;
    logic        complete;
    logic        grantOpp;
    logic        pickDbg;
    logic        grantIf;
    logic        grantDbg;
    logic [31:0] rspData;

    // Grant decision. A new read may start in IDLE or in the same cycle the
    // current response is accepted, which gives one read per cycle when the
    // owner keeps RSP_READY high. Grants are masked while RST_N is low so the
    // BRAM sees no enable during reset.
    always_comb begin
        rspActive     = (state_q == StBusy) || (state_q == StHold);
        ownerRspReady = (owner_q == OwnDbg) ? DBG_RSP_READY : IF_RSP_READY;
        complete      = rspActive && ownerRspReady;
        grantOpp      = RST_N && ((state_q == StIdle) || complete);
`ifdef IMEM_ARB_RR_EN
        // On contention, DBG wins only if IF was granted last.
        pickDbg       = DBG_REQ_VALID && (!IF_REQ_VALID || !lastDbg_q);
`else
        pickDbg       = DBG_REQ_VALID && !IF_REQ_VALID;
`endif
        grantIf       = grantOpp && IF_REQ_VALID && !pickDbg;
        grantDbg      = grantOpp && pickDbg;
        // BUSY passes the BRAM word through; HOLD replays the parked word.
        rspData       = (state_q == StHold) ? hold_q : MEM_RDATA;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = hold_q;
`ifdef IMEM_ARB_RR_EN
        lastDbg_d = lastDbg_q;
`endif
        if (grantIf || grantDbg) begin
            state_d = StBusy;
            owner_d = grantDbg ? OwnDbg : OwnIf;
`ifdef IMEM_ARB_RR_EN
            lastDbg_d = grantDbg;
`endif
        end else if ((state_q == StBusy) && !ownerRspReady) begin
            // The BRAM word is only valid this cycle, so park it.
            state_d = StHold;
            hold_d  = MEM_RDATA;
        end else if (complete) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            hold_q  <= '0;
`ifdef IMEM_ARB_RR_EN
            lastDbg_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
`ifdef IMEM_ARB_RR_EN
            lastDbg_q <= lastDbg_d;
`endif
        end
    end

    // Outputs. Non-owner and idle ports see zeros on valid and data.
    always_comb begin
        MEM_EN        = grantIf || grantDbg;
        MEM_ADDR      = grantDbg ? DBG_ADDR : (grantIf ? IF_ADDR : '0);
        IF_REQ_READY  = grantIf;
        DBG_REQ_READY = grantDbg;
        IF_RSP_VALID  = rspActive && (owner_q == OwnIf);
        DBG_RSP_VALID = rspActive && (owner_q == OwnDbg);
        IF_RDATA      = IF_RSP_VALID  ? rspData : 32'h0;
        DBG_RDATA     = DBG_RSP_VALID ? rspData : 32'h0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Self-checking bench for imem_arbiter. A behavioural BRAM with a 1-cycle
// registered read sits on the memory port. A table of per-cycle vectors
// drives both requesters and lists the expected outputs for that cycle.
// Hand-written sequences cover reset behaviour, including reset while a read
// is outstanding. The arbitration expectations follow IMEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          IF_REQ_VALID, IF_REQ_READY, IF_RSP_VALID, IF_RSP_READY;
    logic [AW-1:0] IF_ADDR;
    logic [31:0]   IF_RDATA;
    logic          DBG_REQ_VALID, DBG_REQ_READY, DBG_RSP_VALID, DBG_RSP_READY;
    logic [AW-1:0] DBG_ADDR;
    logic [31:0]   DBG_RDATA;
    logic          MEM_EN;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_RDATA = 32'h0;

    logic [31:0]   ram [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          ifValid;
        logic [AW-1:0] ifAddr;
        logic          ifRspReady;
        logic          dbgValid;
        logic [AW-1:0] dbgAddr;
        logic          dbgRspReady;
        logic          expMemEn;
        logic [AW-1:0] expMemAddr;
        logic          expIfReady;
        logic          expDbgReady;
        logic          expIfRspValid;
        logic [31:0]   expIfRdata;
        logic          expDbgRspValid;
        logic [31:0]   expDbgRdata;
    } vec_t;

    vec_t vecs[$];

    imem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .IF_REQ_VALID  (IF_REQ_VALID),
        .IF_REQ_READY  (IF_REQ_READY),
        .IF_ADDR       (IF_ADDR),
        .IF_RSP_VALID  (IF_RSP_VALID),
        .IF_RSP_READY  (IF_RSP_READY),
        .IF_RDATA      (IF_RDATA),
        .DBG_REQ_VALID (DBG_REQ_VALID),
        .DBG_REQ_READY (DBG_REQ_READY),
        .DBG_ADDR      (DBG_ADDR),
        .DBG_RSP_VALID (DBG_RSP_VALID),
        .DBG_RSP_READY (DBG_RSP_READY),
        .DBG_RDATA     (DBG_RDATA),
        .MEM_EN        (MEM_EN),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_RDATA     (MEM_RDATA)
    );

    // Free-running clock, period 10.
    always #5 CLK = ~CLK;

    // Behavioural BRAM: registered read, output holds when EN is low.
    always @(posedge CLK) begin
        if (MEM_EN) MEM_RDATA <= ram[MEM_ADDR[AW-1:2]];
    end

    function automatic logic [31:0] ramWord(input int idx);
        logic [7:0] b;
        b = 8'(idx);
        return {16'hC0DE, b, ~b};
    endfunction

    function automatic vec_t mkVec(
        input logic ifV, input logic [AW-1:0] ifA, input logic ifRr,
        input logic dbgV, input logic [AW-1:0] dbgA, input logic dbgRr,
        input logic mEn, input logic [AW-1:0] mAddr,
        input logic ifRdy, input logic dbgRdy,
        input logic ifRv, input logic [31:0] ifRd,
        input logic dbgRv, input logic [31:0] dbgRd);
        vec_t v;
        v.ifValid = ifV;   v.ifAddr = ifA;   v.ifRspReady = ifRr;
        v.dbgValid = dbgV; v.dbgAddr = dbgA; v.dbgRspReady = dbgRr;
        v.expMemEn = mEn;  v.expMemAddr = mAddr;
        v.expIfReady = ifRdy; v.expDbgReady = dbgRdy;
        v.expIfRspValid = ifRv;   v.expIfRdata = ifRd;
        v.expDbgRspValid = dbgRv; v.expDbgRdata = dbgRd;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        IF_REQ_VALID  = v.ifValid;
        IF_ADDR       = v.ifAddr;
        IF_RSP_READY  = v.ifRspReady;
        DBG_REQ_VALID = v.dbgValid;
        DBG_ADDR      = v.dbgAddr;
        DBG_RSP_READY = v.dbgRspReady;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("v%0d.MEM_EN", idx),        32'(MEM_EN),        32'(v.expMemEn));
        checkVal($sformatf("v%0d.MEM_ADDR", idx),      32'(MEM_ADDR),      32'(v.expMemAddr));
        checkVal($sformatf("v%0d.IF_REQ_READY", idx),  32'(IF_REQ_READY),  32'(v.expIfReady));
        checkVal($sformatf("v%0d.DBG_REQ_READY", idx), 32'(DBG_REQ_READY), 32'(v.expDbgReady));
        checkVal($sformatf("v%0d.IF_RSP_VALID", idx),  32'(IF_RSP_VALID),  32'(v.expIfRspValid));
        checkVal($sformatf("v%0d.IF_RDATA", idx),      IF_RDATA,           v.expIfRdata);
        checkVal($sformatf("v%0d.DBG_RSP_VALID", idx), 32'(DBG_RSP_VALID), 32'(v.expDbgRspValid));
        checkVal($sformatf("v%0d.DBG_RDATA", idx),     DBG_RDATA,          v.expDbgRdata);
    endtask

    task automatic idleInputs();
        applyStimulus(mkVec(0, '0, 1, 0, '0, 1, 0, '0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = ramWord(i);

        // Fetch-only streaming: three back-to-back reads, then drain.
        vecs.push_back(mkVec(1, 10'h004, 1, 0, 10'h000, 1,  1, 10'h004, 1, 0,  0, 0,          0, 0));
        vecs.push_back(mkVec(1, 10'h008, 1, 0, 10'h000, 1,  1, 10'h008, 1, 0,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(1, 10'h00C, 1, 0, 10'h000, 1,  1, 10'h00C, 1, 0,  1, ramWord(2), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  1, ramWord(3), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          0, 0));
        // Fetch response stalled 3 cycles; DBG waits, word is held.
        vecs.push_back(mkVec(1, 10'h010, 0, 0, 10'h000, 1,  1, 10'h010, 1, 0,  0, 0,          0, 0));
        vecs.push_back(mkVec(0, 10'h000, 0, 1, 10'h020, 1,  0, 10'h000, 0, 0,  1, ramWord(4), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 0, 1, 10'h020, 1,  0, 10'h000, 0, 0,  1, ramWord(4), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 0, 1, 10'h020, 1,  0, 10'h000, 0, 0,  1, ramWord(4), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 1, 10'h020, 1,  1, 10'h020, 0, 1,  1, ramWord(4), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          1, ramWord(8)));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          0, 0));
        // Contention for four grants; last grant before this was DBG.
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h004, 1, 0,  0, 0,          0, 0));
`ifdef IMEM_ARB_RR_EN
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h008, 0, 1,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h004, 1, 0,  0, 0,          1, ramWord(2)));
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h008, 0, 1,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          1, ramWord(2)));
`else
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h004, 1, 0,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h004, 1, 0,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(1, 10'h004, 1, 1, 10'h008, 1,  1, 10'h004, 1, 0,  1, ramWord(1), 0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  1, ramWord(1), 0, 0));
`endif
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          0, 0));
        // Misaligned debug address goes out unmodified.
        vecs.push_back(mkVec(0, 10'h000, 1, 1, 10'h023, 1,  1, 10'h023, 0, 1,  0, 0,          0, 0));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          1, ramWord(8)));
        vecs.push_back(mkVec(0, 10'h000, 1, 0, 10'h000, 1,  0, 10'h000, 0, 0,  0, 0,          0, 0));

        // Reset with both requesters asserting: nothing may be granted.
        RST_N = 1'b0;
        applyStimulus(mkVec(1, 10'h004, 1, 1, 10'h008, 1, 0, '0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkVal("rst.MEM_EN",        32'(MEM_EN),        32'h0);
        checkVal("rst.MEM_ADDR",      32'(MEM_ADDR),      32'h0);
        checkVal("rst.IF_REQ_READY",  32'(IF_REQ_READY),  32'h0);
        checkVal("rst.DBG_REQ_READY", 32'(DBG_REQ_READY), 32'h0);
        checkVal("rst.IF_RSP_VALID",  32'(IF_RSP_VALID),  32'h0);
        checkVal("rst.DBG_RSP_VALID", 32'(DBG_RSP_VALID), 32'h0);
        @(posedge CLK); #1;
        idleInputs();
        RST_N = 1'b1;

        // Table-driven cycles.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge CLK);
            checkOutput(vecs[i], i);
            @(posedge CLK); #1;
        end

        // Reset while a debug read is in BUSY.
        applyStimulus(mkVec(0, '0, 1, 1, 10'h020, 0, 0, '0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        checkVal("rb.DBG_REQ_READY", 32'(DBG_REQ_READY), 32'h1);
        checkVal("rb.MEM_ADDR",      32'(MEM_ADDR),      32'h020);
        @(posedge CLK); #1;
        DBG_REQ_VALID = 1'b0;
        @(negedge CLK);
        checkVal("rb.busy.DBG_RSP_VALID", 32'(DBG_RSP_VALID), 32'h1);
        checkVal("rb.busy.DBG_RDATA",     DBG_RDATA,          ramWord(8));
        #1;
        RST_N = 1'b0;
        #1;
        checkVal("rb.now.DBG_RSP_VALID", 32'(DBG_RSP_VALID), 32'h0);
        checkVal("rb.now.DBG_RDATA",     DBG_RDATA,          32'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checkVal($sformatf("rb.after%0d.DBG_RSP_VALID", c), 32'(DBG_RSP_VALID), 32'h0);
            checkVal($sformatf("rb.after%0d.IF_RSP_VALID", c),  32'(IF_RSP_VALID),  32'h0);
            checkVal($sformatf("rb.after%0d.MEM_EN", c),        32'(MEM_EN),        32'h0);
            @(posedge CLK); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
